// File: rtl/fb_rect_fill.sv
// Rectangle-fill engine for the 640x480 palette-index framebuffer.
// Takes one command at a time, clips it to the visible area and writes one
// pixel per clock in raster order through the framebuffer write port.
module fb_rect_fill #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 4
) (
  input  logic              clk_100m,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [9:0]        cmd_x0,
  input  logic [9:0]        cmd_y0,
  input  logic [9:0]        cmd_w,
  input  logic [9:0]        cmd_h,
  input  logic [DATA_W-1:0] cmd_color,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_en,
  output logic              bram_we
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_FILL, S_DONE} state_t;

  localparam logic [10:0]       H_LIM    = 11'(H_RES);
  localparam logic [10:0]       V_LIM    = 11'(V_RES);
  localparam logic [ADDR_W-1:0] H_STRIDE = ADDR_W'(H_RES);

  state_t              r_state;
  logic [9:0]          r_x0, r_y0, r_w, r_h;
  logic [DATA_W-1:0]   r_color;
  logic [9:0]          r_x;
  logic [9:0]          r_row;
  logic [10:0]         r_x_last;
  logic [10:0]         r_row_last;
  logic [ADDR_W-1:0]   r_row_base;
  logic                r_cmd_ready, r_busy, r_done, r_bram_en;
  logic [ADDR_W-1:0]   r_bram_addr;
  logic [DATA_W-1:0]   r_bram_din;

  // Clipping: 11-bit sums so x0+w / y0+h never wrap before the min().
  logic [10:0]       w_x_sum, w_y_sum, w_x_end, w_y_end;
  logic              w_x_vis, w_y_vis;
  logic [10:0]       w_x_last, w_row_last;
  logic [ADDR_W-1:0] w_y0_ext, w_row_base, w_first_addr, w_next_base;
  logic              w_last_col, w_last_row;

  assign w_x_sum  = {1'b0, r_x0} + {1'b0, r_w};
  assign w_y_sum  = {1'b0, r_y0} + {1'b0, r_h};
  assign w_x_end  = (w_x_sum > H_LIM) ? H_LIM : w_x_sum;
  assign w_y_end  = (w_y_sum > V_LIM) ? V_LIM : w_y_sum;
  // A zero-width or off-screen span shows up as end <= start.
  assign w_x_vis  = ({1'b0, r_x0} < H_LIM) && (w_x_end > {1'b0, r_x0});
  assign w_y_vis  = ({1'b0, r_y0} < V_LIM) && (w_y_end > {1'b0, r_y0});
  assign w_x_last   = w_x_end - 11'd1;
  assign w_row_last = w_y_end - {1'b0, r_y0} - 11'd1;

  // y0*640 as (y0<<9)+(y0<<7): two shifts and an adder, no multiplier.
  assign w_y0_ext     = ADDR_W'(r_y0);
  assign w_row_base   = (w_y0_ext << 9) + (w_y0_ext << 7);
  assign w_first_addr = w_row_base + ADDR_W'(r_x0);
  assign w_next_base  = r_row_base + H_STRIDE;

  assign w_last_col = ({1'b0, r_x}   == r_x_last);
  assign w_last_row = ({1'b0, r_row} == r_row_last);

  // Command FSM; every port-facing output is a flop updated here.
  // NOTE: reset is synchronous, so it is tested inside the clocked block
  // rather than listed in the sensitivity list.
  always_ff @(posedge clk_100m) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_x0        <= '0;
      r_y0        <= '0;
      r_w         <= '0;
      r_h         <= '0;
      r_color     <= '0;
      r_x         <= '0;
      r_row       <= '0;
      r_x_last    <= '0;
      r_row_last  <= '0;
      r_row_base  <= '0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_bram_en   <= 1'b0;
      r_bram_addr <= '0;
      r_bram_din  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop reading the values
      // from before this edge, independent of statement order.
      unique case (r_state)
        S_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_x0        <= cmd_x0;
            r_y0        <= cmd_y0;
            r_w         <= cmd_w;
            r_h         <= cmd_h;
            r_color     <= cmd_color;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (w_x_vis && w_y_vis) begin
            // Load the first pixel so it is on the port in the first FILL cycle.
            r_x         <= r_x0;
            r_row       <= '0;
            r_x_last    <= w_x_last;
            r_row_last  <= w_row_last;
            r_row_base  <= w_row_base;
            r_bram_addr <= w_first_addr;
            r_bram_din  <= r_color;
            r_bram_en   <= 1'b1;
            r_state     <= S_FILL;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_FILL: begin
          // The port currently shows pixel (r_x, r_row); pick the next one.
          if (w_last_col) begin
            if (w_last_row) begin
              r_bram_en <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_x         <= r_x0;
              r_row       <= r_row + 10'd1;
              r_row_base  <= w_next_base;
              r_bram_addr <= w_next_base + ADDR_W'(r_x0);
            end
          end else begin
            r_x         <= r_x + 10'd1;
            r_bram_addr <= r_bram_addr + ADDR_W'(1);
          end
        end

        S_DONE: begin
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign bram_en   = r_bram_en;
  assign bram_we   = r_bram_en;
  assign bram_addr = r_bram_addr;
  assign bram_din  = r_bram_din;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed testbench for fb_rect_fill. Outputs are sampled on the falling
// edge; "cycle k+n" is the n-th falling edge after the accepting rising edge.
module tb_fb_rect_fill;

  logic        clk_100m = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_x0, cmd_y0, cmd_w, cmd_h;
  logic [3:0]  cmd_color;
  logic        busy, done;
  logic [18:0] bram_addr;
  logic [3:0]  bram_din;
  logic        bram_en, bram_we;

  int total = 0;
  int bad   = 0;

  // {cmd_ready, busy, done, bram_en, bram_we}
  logic [4:0] obs;
  assign obs = {cmd_ready, busy, done, bram_en, bram_we};

  localparam logic [4:0] OBS_IDLE  = 5'b10000;
  localparam logic [4:0] OBS_SETUP = 5'b01000;
  localparam logic [4:0] OBS_WRITE = 5'b01011;
  localparam logic [4:0] OBS_DONE  = 5'b01100;

  fb_rect_fill dut (
    .clk_100m  (clk_100m),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .busy      (busy),
    .done      (done),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .bram_en   (bram_en),
    .bram_we   (bram_we)
  );

  always #5 clk_100m = ~clk_100m;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus only: wait for ready, present one command for exactly one edge.
  task automatic issue(input logic [9:0] x0, input logic [9:0] y0,
                       input logic [9:0] w, input logic [9:0] h,
                       input logic [3:0] c);
    int n;
    n = 0;
    @(negedge clk_100m);
    while (!cmd_ready && n < 50) begin
      @(negedge clk_100m);
      n++;
    end
    if (!cmd_ready) begin
      total++; bad++;
      $display("FAIL issue_wait: cmd_ready=%0b want 1 within 50 cycles", cmd_ready);
    end
    cmd_x0 = x0; cmd_y0 = y0; cmd_w = w; cmd_h = h; cmd_color = c;
    cmd_valid = 1'b1;
    @(posedge clk_100m);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cmd_valid = 1'b0;
    cmd_x0 = '0; cmd_y0 = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    repeat (3) @(posedge clk_100m);
    @(negedge clk_100m);
    total++;
    if (obs !== OBS_IDLE) begin
      bad++; $display("FAIL reset_flags: got %b want %b", obs, OBS_IDLE);
    end
    total++;
    if (bram_addr !== 19'd0 || bram_din !== 4'd0) begin
      bad++; $display("FAIL reset_port: addr=%0d din=%0d want 0 0", bram_addr, bram_din);
    end
    reset = 1'b1;
    @(negedge clk_100m);
    total++;
    if (obs !== OBS_IDLE) begin
      bad++; $display("FAIL reset_release: got %b want %b", obs, OBS_IDLE);
    end
  endtask

  task automatic test_single_pixel();
    issue(10'd639, 10'd479, 10'd1, 10'd1, 4'hF);
    @(negedge clk_100m);
    total++;
    if (obs !== OBS_SETUP) begin
      bad++; $display("FAIL single_setup: got %b want %b", obs, OBS_SETUP);
    end
    @(negedge clk_100m);
    total++;
    if (obs !== OBS_WRITE || bram_addr !== 19'd307199 || bram_din !== 4'hF) begin
      bad++; $display("FAIL single_write: flags=%b addr=%0d din=%0h want %b 307199 f",
                      obs, bram_addr, bram_din, OBS_WRITE);
    end
    @(negedge clk_100m);
    total++;
    if (obs !== OBS_DONE) begin
      bad++; $display("FAIL single_done: got %b want %b", obs, OBS_DONE);
    end
    @(negedge clk_100m);
    total++;
    if (obs !== OBS_IDLE) begin
      bad++; $display("FAIL single_ready: got %b want %b", obs, OBS_IDLE);
    end
  endtask

  task automatic test_rect();
    int exp_a[6] = '{1290, 1291, 1292, 1930, 1931, 1932};
    issue(10'd10, 10'd2, 10'd3, 10'd2, 4'h7);
    @(negedge clk_100m);
    total++;
    if (obs !== OBS_SETUP) begin
      bad++; $display("FAIL rect_setup: got %b want %b", obs, OBS_SETUP);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_100m);
      total++;
      if (obs !== OBS_WRITE || bram_addr !== 19'(exp_a[i]) || bram_din !== 4'h7) begin
        bad++; $display("FAIL rect_write%0d: flags=%b addr=%0d din=%0h want %b %0d 7",
                        i, obs, bram_addr, bram_din, OBS_WRITE, exp_a[i]);
      end
    end
    @(negedge clk_100m);
    total++;
    if (obs !== OBS_DONE) begin
      bad++; $display("FAIL rect_done: got %b want %b", obs, OBS_DONE);
    end
    @(negedge clk_100m);
    total++;
    if (obs !== OBS_IDLE) begin
      bad++; $display("FAIL rect_ready: got %b want %b", obs, OBS_IDLE);
    end
  endtask

  task automatic test_clip();
    // Right-edge clip: only columns 638 and 639 on line 0.
    issue(10'd638, 10'd0, 10'd5, 10'd1, 4'h3);
    @(negedge clk_100m);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_100m);
      total++;
      if (obs !== OBS_WRITE || bram_addr !== 19'(638 + i) || bram_din !== 4'h3) begin
        bad++; $display("FAIL clipx_write%0d: flags=%b addr=%0d din=%0h want %b %0d 3",
                        i, obs, bram_addr, bram_din, OBS_WRITE, 638 + i);
      end
    end
    @(negedge clk_100m);
    total++;
    if (obs !== OBS_DONE) begin
      bad++; $display("FAIL clipx_done: got %b want %b", obs, OBS_DONE);
    end

    // Bottom-edge clip: lines 478 and 479 of column 0.
    issue(10'd0, 10'd478, 10'd1, 10'd10, 4'hA);
    @(negedge clk_100m);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_100m);
      total++;
      if (obs !== OBS_WRITE || bram_addr !== 19'(305920 + 640 * i) || bram_din !== 4'hA) begin
        bad++; $display("FAIL clipy_write%0d: flags=%b addr=%0d din=%0h want %b %0d a",
                        i, obs, bram_addr, bram_din, OBS_WRITE, 305920 + 640 * i);
      end
    end
    @(negedge clk_100m);
    total++;
    if (obs !== OBS_DONE) begin
      bad++; $display("FAIL clipy_done: got %b want %b", obs, OBS_DONE);
    end
  endtask

  task automatic test_zero_area();
    logic [9:0] zx[3] = '{10'd640, 10'd10, 10'd5};
    logic [9:0] zy[3] = '{10'd0,   10'd10, 10'd480};
    logic [9:0] zw[3] = '{10'd5,   10'd0,  10'd4};
    for (int t = 0; t < 3; t++) begin
      issue(zx[t], zy[t], zw[t], 10'd4, 4'h3);
      @(negedge clk_100m);
      total++;
      if (obs !== OBS_SETUP) begin
        bad++; $display("FAIL zero%0d_setup: got %b want %b", t, obs, OBS_SETUP);
      end
      @(negedge clk_100m);
      total++;
      if (obs !== OBS_DONE) begin
        bad++; $display("FAIL zero%0d_done: got %b want %b", t, obs, OBS_DONE);
      end
      @(negedge clk_100m);
      total++;
      if (obs !== OBS_IDLE) begin
        bad++; $display("FAIL zero%0d_ready: got %b want %b", t, obs, OBS_IDLE);
      end
    end
  endtask

  task automatic test_reset_abort();
    issue(10'd0, 10'd0, 10'd10, 10'd10, 4'h5);
    @(negedge clk_100m);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_100m);
      total++;
      if (obs !== OBS_WRITE || bram_addr !== 19'(i)) begin
        bad++; $display("FAIL abort_write%0d: flags=%b addr=%0d want %b %0d",
                        i, obs, bram_addr, OBS_WRITE, i);
      end
    end
    // Reset is sampled at the edge ending the 4th FILL cycle.
    reset = 1'b0;
    @(negedge clk_100m);
    total++;
    if (obs !== OBS_IDLE || bram_addr !== 19'd0) begin
      bad++; $display("FAIL abort_reset: flags=%b addr=%0d want %b 0", obs, bram_addr, OBS_IDLE);
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_100m);
      total++;
      if (obs !== OBS_IDLE) begin
        bad++; $display("FAIL abort_quiet%0d: got %b want %b", i, obs, OBS_IDLE);
      end
    end
    issue(10'd20, 10'd0, 10'd1, 10'd1, 4'h1);
    @(negedge clk_100m);
    @(negedge clk_100m);
    total++;
    if (obs !== OBS_WRITE || bram_addr !== 19'd20 || bram_din !== 4'h1) begin
      bad++; $display("FAIL abort_new_write: flags=%b addr=%0d din=%0h want %b 20 1",
                      obs, bram_addr, bram_din, OBS_WRITE);
    end
    @(negedge clk_100m);
    total++;
    if (obs !== OBS_DONE) begin
      bad++; $display("FAIL abort_new_done: got %b want %b", obs, OBS_DONE);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  exp_f[9];
    logic [18:0] exp_a[9];
    logic [3:0]  exp_d[9];
    exp_f = '{OBS_SETUP, OBS_WRITE, OBS_WRITE, OBS_DONE, OBS_IDLE,
              OBS_SETUP, OBS_WRITE, OBS_DONE, OBS_IDLE};
    exp_a = '{19'd0, 19'd740, 19'd741, 19'd0, 19'd0, 19'd0, 19'd5, 19'd0, 19'd0};
    exp_d = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h9, 4'h0, 4'h0};
    @(negedge clk_100m);
    @(negedge clk_100m);
    // Command A: 2x1 at (100,1); N=2, so B is taken at edge k+5.
    cmd_x0 = 10'd100; cmd_y0 = 10'd1; cmd_w = 10'd2; cmd_h = 10'd1; cmd_color = 4'h2;
    cmd_valid = 1'b1;
    @(posedge clk_100m);
    // Command B queued behind A with valid held high.
    #1;
    cmd_x0 = 10'd5; cmd_y0 = 10'd0; cmd_w = 10'd1; cmd_h = 10'd1; cmd_color = 4'h9;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk_100m);
      total++;
      if (obs !== exp_f[i] || (exp_f[i] == OBS_WRITE &&
          (bram_addr !== exp_a[i] || bram_din !== exp_d[i]))) begin
        bad++; $display("FAIL b2b_cycle%0d: flags=%b addr=%0d din=%0h want %b %0d %0h",
                        i + 1, obs, bram_addr, bram_din, exp_f[i], exp_a[i], exp_d[i]);
      end
      if (i == 5) cmd_valid = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_rect();
    test_clip();
    test_zero_area();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
